// File: rtl/pin_bus_arbiter.sv
// Round-robin owner arbitration for the shared tristate pin bus, with a forced
// idle+turnaround gap between owners. Optional hold timeout: PIN_BUS_ARB_TIMEOUT_EN.
module pin_bus_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         done,
  input  logic [NREQ-1:0]         oe_req,
  input  logic [NREQ*WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic                    expired,
  output logic [WIDTH-1:0]        pin_out,
  output logic                    pin_oe,
  input  logic [WIDTH-1:0]        pin_in,
  output logic [WIDTH-1:0]        rdata
);

  localparam int unsigned PW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_TURN = 2'd1;
  localparam logic [1:0] ST_OWN  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    cand_q, cand_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [WIDTH-1:0] pin_out_q, pin_out_d;
  logic             pin_oe_q, pin_oe_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic [PW-1:0]    pick_c;
  logic             pick_vld_c;
  logic [PW-1:0]    idx_c;
  logic [WIDTH-1:0] owner_wdata_c;
  logic             timeout_c;

  // Scan from the far end back to ptr so the nearest requester is written last and wins.
  always_comb begin
    pick_c     = '0;
    pick_vld_c = 1'b0;
    idx_c      = '0;
    for (int unsigned i = NREQ; i > 0; i--) begin
      idx_c = PW'((32'(ptr_q) + i - 1) % NREQ);
      if (req[idx_c]) begin
        pick_c     = idx_c;
        pick_vld_c = 1'b1;
      end
    end
  end

  always_comb begin
    owner_wdata_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (PW'(i) == cand_q) owner_wdata_c = wdata[i*WIDTH +: WIDTH];
    end
  end

`ifdef PIN_BUS_ARB_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD);

  logic [HW-1:0] hold_q, hold_d;
  logic          expired_q, expired_d;

  assign timeout_c = (state_q == ST_OWN) && (hold_q == HW'(MAX_HOLD - 1));

  // Hold counter restarts on the TURN->OWN edge and counts owned cycles.
  always_comb begin
    hold_d    = hold_q;
    expired_d = timeout_c;
    if (state_q == ST_TURN) begin
      hold_d = '0;
    end else if (state_q == ST_OWN) begin
      hold_d = timeout_c ? '0 : hold_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q    <= '0;
      expired_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      expired_q <= expired_d;
    end
  end

  assign expired = expired_q;
`else
  logic unused_max_hold;

  assign unused_max_hold = ^(32'(MAX_HOLD));
  assign timeout_c       = 1'b0;
  assign expired         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cand_d    = cand_q;
    gnt_d     = gnt_q;
    pin_out_d = pin_out_q;
    pin_oe_d  = pin_oe_q;
    rdata_d   = pin_in;
    case (state_q)
      ST_IDLE: begin
        gnt_d    = '0;
        pin_oe_d = 1'b0;
        if (pick_vld_c) begin
          cand_d  = pick_c;
          state_d = ST_TURN;
        end
      end
      ST_TURN: begin
        gnt_d    = '0;
        pin_oe_d = 1'b0;
        if (req[cand_q]) begin
          gnt_d[cand_q] = 1'b1;
          state_d       = ST_OWN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN: begin
        // Any release cause ends ownership; pin_out keeps its last value.
        if (done[cand_q] || !req[cand_q] || timeout_c) begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          pin_oe_d = 1'b0;
          ptr_d    = (cand_q == PW'(NREQ - 1)) ? '0 : cand_q + 1'b1;
        end else begin
          pin_out_d = owner_wdata_c;
          pin_oe_d  = oe_req[cand_q];
        end
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        pin_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      cand_q    <= '0;
      gnt_q     <= '0;
      pin_out_q <= '0;
      pin_oe_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cand_q    <= cand_d;
      gnt_q     <= gnt_d;
      pin_out_q <= pin_out_d;
      pin_oe_q  <= pin_oe_d;
      rdata_q   <= rdata_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = |gnt_q;
  assign pin_out = pin_out_q;
  assign pin_oe  = pin_oe_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_pin_bus_arbiter.sv
// Scoreboard bench for pin_bus_arbiter: stimulus queues timestamped expected
// output changes, a negedge monitor pops one per observed change.
module tb_pin_bus_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;

  logic                  clock = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req, done, oe_req, gnt;
  logic [NREQ*WIDTH-1:0] wdata;
  logic                  busy, expired, pin_oe;
  logic [WIDTH-1:0]      pin_out, pin_in, rdata;

  pin_bus_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(16)) dut (
    .clock(clock), .reset(reset), .req(req), .done(done), .oe_req(oe_req),
    .wdata(wdata), .gnt(gnt), .busy(busy), .expired(expired),
    .pin_out(pin_out), .pin_oe(pin_oe), .pin_in(pin_in), .rdata(rdata)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] gnt;
    logic       busy;
    logic       expired;
    logic       pin_oe;
    logic [7:0] pin_out;
    logic [7:0] rdata;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t v;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   passes = 0;
  bit   mon_en = 1'b0;
  bit   first  = 1'b1;
  obs_t prev;
  obs_t cur_c;

  logic [3:0] e_gnt;
  logic       e_ex, e_oe;
  logic [7:0] e_po, e_rd;
  int         base;

  assign cur_c = {gnt, busy, expired, pin_oe, pin_out, rdata};

  always @(posedge clock) cyc <= cyc + 1;

  function automatic string fmt(input obs_t o);
    return $sformatf("gnt=%b busy=%b expired=%b oe=%b pin_out=%h rdata=%h",
                     o.gnt, o.busy, o.expired, o.pin_oe, o.pin_out, o.rdata);
  endfunction

  // Every change of the observed outputs must match the next queued expectation.
  always @(negedge clock) begin : mon
    exp_t e;
    if (mon_en) begin
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        checks++;
        $display("FAIL missing_change at cyc=%0d: got %s, required %s", e.cyc, fmt(cur_c), fmt(e.v));
      end
      if (first || cur_c != prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_change cyc=%0d: got %s, required no change", cyc, fmt(cur_c));
        end else begin
          e = exp_q.pop_front();
          if (e.cyc == cyc && e.v == cur_c) passes++;
          else $display("FAIL event cyc=%0d: got %s, required cyc=%0d %s",
                        cyc, fmt(cur_c), e.cyc, fmt(e.v));
        end
        first = 1'b0;
      end
      prev = cur_c;
    end
  end

  task automatic push(input int dc);
    exp_t e;
    e.cyc = base + dc;
    e.v   = {e_gnt, |e_gnt, e_ex, e_oe, e_po, e_rd};
    exp_q.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_w(input int i, input logic [7:0] v);
    wdata[i*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    reset = 1'b1; req = '0; done = '0; oe_req = '0; wdata = '0; pin_in = '0;
    e_gnt = '0; e_ex = 1'b0; e_oe = 1'b0; e_po = '0; e_rd = '0;
    cycles(2);
    reset = 1'b0; mon_en = 1'b1; base = cyc;
    push(0);
    cycles(2);

    // Round robin from ptr=0: owners 0,1,2,3,0, three owned cycles each.
    base = cyc; req = 4'hF; oe_req = 4'hF;
    for (int i = 0; i < 4; i++) set_w(i, 8'(16 + i));
    for (int k = 0; k < 5; k++) begin
      e_gnt = 4'(1 << (k % 4)); push(2 + 5 * k);
      e_oe = 1'b1; e_po = 8'(16 + (k % 4)); push(3 + 5 * k);
      e_gnt = '0; e_oe = 1'b0; push(5 + 5 * k);
    end
    for (int k = 0; k < 5; k++) begin
      cycles(4); done = 4'(1 << (k % 4));
      cycles(1); done = '0;
    end
    req = '0; oe_req = '0;
    cycles(3);

    // Single requester 2 driving 0xA5.
    base = cyc; set_w(2, 8'hA5); req = 4'b0100; oe_req = 4'b0100;
    e_gnt = 4'b0100; push(2);
    e_oe = 1'b1; e_po = 8'hA5; push(3);
    e_gnt = '0; e_oe = 1'b0; push(6);
    cycles(5); done = 4'b0100;
    cycles(1); done = '0; req = '0; oe_req = '0;
    cycles(3);

    // Requester 1 withdraws during TURN; requester 3 then granted.
    req = 4'b0010; cycles(1); req = '0; cycles(2);
    base = cyc; set_w(3, 8'h5A); req = 4'b1000; oe_req = 4'b1000;
    e_gnt = 4'b1000; push(2);
    e_oe = 1'b1; e_po = 8'h5A; push(3);
    e_gnt = '0; e_oe = 1'b0; push(4);
    cycles(3); done = 4'b1000;
    cycles(1); done = '0; req = '0; oe_req = '0;
    cycles(3);

    // Owner 0 at 0x3C ignores requester 2's done/oe_req/wdata/req.
    base = cyc; set_w(0, 8'h3C); req = 4'b0001; oe_req = 4'b0001;
    e_gnt = 4'b0001; push(2);
    e_oe = 1'b1; e_po = 8'h3C; push(3);
    cycles(3); done = 4'b0100; oe_req = 4'b0101; set_w(2, 8'hFF); req = 4'b0101;
    cycles(1); done = '0; oe_req = 4'b0001;
    cycles(1); done = 4'b0100;
    cycles(1); done = '0;
    base = cyc; done = 4'b0001; req = 4'b0100; oe_req = '0;
    e_gnt = '0; e_oe = 1'b0; push(1);
    e_gnt = 4'b0100; push(3);
    e_po = 8'hFF; push(4);
    e_gnt = '0; push(5);
    cycles(1); done = '0;
    cycles(3); done = 4'b0100;
    cycles(1); done = '0; req = '0;
    cycles(3);

    // Long hold by requester 0 with requester 1 pending.
    base = cyc; req = 4'b0011;
    e_gnt = 4'b0001; push(2);
    e_po = 8'h3C; push(3);
`ifdef PIN_BUS_ARB_TIMEOUT_EN
    e_gnt = '0; e_ex = 1'b1; push(18);
    e_ex = 1'b0; push(19);
    e_gnt = 4'b0010; push(20);
    e_po = 8'h11; push(21);
    e_gnt = '0; push(22);
    cycles(21); req = '0;
`else
    e_gnt = '0; push(26);
    e_gnt = 4'b0010; push(28);
    e_po = 8'h11; push(29);
    e_gnt = '0; push(30);
    cycles(25); done = 4'b0001;
    cycles(1); done = '0;
    cycles(3); req = '0;
`endif
    cycles(3);

    // Reset mid-ownership, then ptr restarts at 0.
    base = cyc; set_w(1, 8'h77); req = 4'b0010; oe_req = 4'b0010; pin_in = 8'h96;
    e_rd = 8'h96; push(1);
    e_gnt = 4'b0010; push(2);
    e_oe = 1'b1; e_po = 8'h77; push(3);
    e_gnt = '0; e_oe = 1'b0; e_po = '0; e_rd = '0; push(4);
    e_rd = 8'h96; push(5);
    e_gnt = 4'b0010; push(6);
    e_oe = 1'b1; e_po = 8'h77; push(7);
    e_gnt = '0; e_oe = 1'b0; push(8);
    e_gnt = 4'b0100; push(10);
    e_po = 8'hFF; push(11);
    e_gnt = '0; push(12);
    cycles(3); reset = 1'b1;
    cycles(1); reset = 1'b0; req = 4'b0110;
    cycles(3); done = 4'b0010;
    cycles(1); done = '0; req = 4'b0100;
    cycles(3); req = '0;
    cycles(5);

    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL pending_events: got %0d expected changes never seen, required 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
